// File: rtl/rr_spill_arbiter_pkg.sv
// Helpers shared by the round-robin spill arbiter: cyclic index arithmetic
// that wraps explicitly, so the input count need not be a power of two.
package rr_spill_arbiter_pkg;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic int unsigned rr_slot(input int unsigned base, input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_spill_arbiter_spill_register.sv
// Two-entry spill register: cuts every combinational path between the input
// and output sides while sustaining one transfer per cycle.
module spill_register #(
  parameter int unsigned T_w = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [T_w-1:0] data_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [T_w-1:0] data_o
);

  logic           a_full_q, b_full_q;
  logic [T_w-1:0] a_data_q, b_data_q;
  logic           a_fill, a_drain, b_fill, b_drain;

  // Slot b only ever holds the older item, so it is presented first.
  assign a_fill  = valid_i && ready_o;
  assign a_drain = a_full_q && !b_full_q;
  assign b_fill  = a_drain && !ready_i;
  assign b_drain = b_full_q && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      if (a_fill || a_drain) a_full_q <= a_fill;
      if (a_fill)            a_data_q <= data_i;
      if (b_fill || b_drain) b_full_q <= b_fill;
      if (b_fill)            b_data_q <= a_data_q;
    end
  end

  assign valid_o = a_full_q || b_full_q;
  assign data_o  = b_full_q ? b_data_q : a_data_q;
  assign ready_o = !a_full_q || !b_full_q;

endmodule

// File: rtl/rr_spill_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready stream among NumInp
// producers; the output side is fully decoupled through a spill register.
module rr_spill_arbiter
  import rr_spill_arbiter_pkg::*;
#(
  parameter  int unsigned NumInp    = 4,
  parameter  int unsigned DataWidth = 32,
  parameter  bit          LockIn    = 1'b1,
  localparam int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumInp-1:0]             inp_valid_i,
  output logic [NumInp-1:0]             inp_ready_o,
  input  logic [NumInp*DataWidth-1:0]   inp_data_i,
  output logic                          oup_valid_o,
  input  logic                          oup_ready_i,
  output logic [DataWidth-1:0]          oup_data_o,
  output logic [IdxWidth-1:0]           oup_idx_o
);

  logic                          arb_valid, arb_ready;
  logic [DataWidth-1:0]          arb_data;
  logic [IdxWidth-1:0]           arb_idx;
  logic [DataWidth+IdxWidth-1:0] spill_out;

  assign arb_valid = |inp_valid_i;

  if (NumInp == 1) begin : gen_single
    assign arb_idx     = '0;
    assign arb_data    = inp_data_i;
    assign inp_ready_o = arb_valid && arb_ready;
  end else begin : gen_multi
    logic [IdxWidth-1:0] rr_q, lock_idx_q, search_idx, grant, slot;
    logic                lock_q;

    // Walk offsets from farthest to nearest so the first valid after rr_q wins.
    always_comb begin
      search_idx = rr_q;
      slot       = '0;
      for (int k = NumInp - 1; k >= 0; k--) begin
        slot = IdxWidth'(rr_slot(32'(rr_q), k, NumInp));
        if (inp_valid_i[slot]) search_idx = slot;
      end
    end

    assign grant   = (LockIn && lock_q) ? lock_idx_q : search_idx;
    assign arb_idx = grant;

    always_comb begin
      arb_data    = '0;
      inp_ready_o = '0;
      for (int i = 0; i < NumInp; i++) begin
        if (grant == IdxWidth'(i)) begin
          arb_data       = inp_data_i[i*DataWidth +: DataWidth];
          inp_ready_o[i] = arb_valid && arb_ready;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_q       <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else if (arb_valid && arb_ready) begin
        rr_q   <= IdxWidth'(rr_next(32'(grant), NumInp));
        lock_q <= 1'b0;
      end else if (LockIn && arb_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end
    end

    if (LockIn) begin : gen_lock_chk
      // A producer that has been offered a grant must keep its request up.
      held_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    lock_q |-> inp_valid_i[lock_idx_q]);
    end
  end

  spill_register #(
    .T_w (DataWidth + IdxWidth)
  ) i_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (arb_valid),
    .ready_o (arb_ready),
    .data_i  ({arb_idx, arb_data}),
    .valid_o (oup_valid_o),
    .ready_i (oup_ready_i),
    .data_o  (spill_out)
  );

  assign oup_data_o = spill_out[DataWidth-1:0];
  assign oup_idx_o  = spill_out[DataWidth+IdxWidth-1:DataWidth];

endmodule

// File: tb/tb_rr_spill_arbiter.sv
// Self-checking bench: queue-based reference model for a 4-input locking
// arbiter plus directed wrap / no-lock checks on a 3-input instance.
module tb_rr_spill_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*DW-1:0] data;
  logic            oup_valid, oup_ready;
  logic [DW-1:0]   oup_data;
  logic [IW-1:0]   oup_idx;

  logic [2:0]      valid3, ready3;
  logic [23:0]     data3;
  logic            oup_valid3, oup_ready3;
  logic [7:0]      oup_data3;
  logic [1:0]      oup_idx3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
  } item_t;

  logic [DW-1:0] stim_q[N][$];
  item_t         out_q[$];
  item_t         delivered[$];
  int            ptr, lock_on, lock_g;
  int            waits[N];

  always #5 clk = ~clk;

  rr_spill_arbiter #(.NumInp(N), .DataWidth(DW), .LockIn(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .inp_valid_i(valid), .inp_ready_o(ready),
    .inp_data_i(data), .oup_valid_o(oup_valid), .oup_ready_i(oup_ready),
    .oup_data_o(oup_data), .oup_idx_o(oup_idx));

  rr_spill_arbiter #(.NumInp(3), .DataWidth(8), .LockIn(1'b0)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .inp_valid_i(valid3), .inp_ready_o(ready3),
    .inp_data_i(data3), .oup_valid_o(oup_valid3), .oup_ready_i(oup_ready3),
    .oup_data_o(oup_data3), .oup_idx_o(oup_idx3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      valid[i] = stim_q[i].size() > 0;
      data[i*DW +: DW] = (stim_q[i].size() > 0) ? stim_q[i][0] : '0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      stim_q[i].delete();
      waits[i] = 0;
    end
    out_q.delete();
    ptr = 0;
    lock_on = 0;
    lock_g = 0;
  endtask

  // One clock cycle: inputs applied now, outputs judged at the falling edge.
  task automatic step();
    int g, any;
    logic [N-1:0] exp_rdy;
    bit in_hs, out_hs;
    item_t obs_it;
    drive_inputs();
    @(negedge clk);
    any = 0;
    g = 0;
    for (int k = N - 1; k >= 0; k--)
      if (stim_q[(ptr + k) % N].size() > 0) begin
        g = (ptr + k) % N;
        any = 1;
      end
    if (lock_on != 0) g = lock_g;
    exp_rdy = (any != 0 && out_q.size() < 2) ? (N'(1) << g) : '0;
    chk("inp_ready", ready, exp_rdy);
    chk("oup_valid", oup_valid, out_q.size() > 0);
    if (out_q.size() > 0) begin
      chk("oup_idx", oup_idx, out_q[0].idx);
      chk("oup_data", oup_data, out_q[0].data);
    end
    in_hs  = exp_rdy != 0;
    out_hs = out_q.size() > 0 && oup_ready;
    obs_it.idx  = int'(oup_idx);
    obs_it.data = oup_data;
    @(posedge clk);
    if (out_hs) begin
      void'(out_q.pop_front());
      delivered.push_back(obs_it);
    end
    if (in_hs) begin
      for (int i = 0; i < N; i++)
        if (i != g && stim_q[i].size() > 0) waits[i]++;
      chk("starve_bound", waits[g] <= N - 1, 1'b1);
      waits[g] = 0;
      out_q.push_back('{g, stim_q[g].pop_front()});
      ptr = (g + 1) % N;
      lock_on = 0;
    end else if (any != 0) begin
      lock_on = 1;
      lock_g = g;
    end
    #1;
  endtask

  task automatic full_reset();
    rst_n = 1'b0;
    model_clear();
    drive_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    valid = '0; data = '0; oup_ready = 1'b0;
    valid3 = '0; data3 = '0; oup_ready3 = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_oup_valid", oup_valid, 1'b0);
    chk("rst_oup_data", oup_data, 0);
    chk("rst_oup_idx", oup_idx, 0);
    chk("rst_inp_ready", ready, 0);
    rst_n = 1'b1;
    step();

    // Fairness: everyone requesting, sink always ready.
    oup_ready = 1'b1;
    delivered.delete();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) stim_q[i].push_back(DW'(i * 16 + k));
    for (int c = 0; c < 13; c++) step();
    for (int k = 0; k < 12; k++)
      chk("fair_idx", (k < delivered.size()) ? delivered[k].idx : -1, k % 4);

    // Backpressure: only two transfers fit while the sink stalls.
    oup_ready = 1'b0;
    delivered.delete();
    stim_q[0].push_back(32'hA);
    stim_q[0].push_back(32'hB);
    stim_q[0].push_back(32'hC);
    for (int c = 0; c < 4; c++) step();
    drive_inputs();
    #1;
    chk("bp_ready_zero", ready, 0);
    oup_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
    chk("bp_count", delivered.size(), 3);
    chk("bp_first", (delivered.size() > 0) ? delivered[0].data : 0, 32'hA);
    chk("bp_second", (delivered.size() > 1) ? delivered[1].data : 0, 32'hB);
    chk("bp_third", (delivered.size() > 2) ? delivered[2].data : 0, 32'hC);

    // Lock: input 2 is stalled with a full buffer; input 0 joins but 2 keeps the grant.
    oup_ready = 1'b0;
    delivered.delete();
    stim_q[2].push_back(32'h21);
    stim_q[2].push_back(32'h22);
    stim_q[2].push_back(32'h23);
    for (int c = 0; c < 3; c++) step();
    stim_q[0].push_back(32'h01);
    step();
    step();
    oup_ready = 1'b1;
    step();
    drive_inputs();
    #1;
    chk("lock_hold", ready, 4'b0100);
    for (int c = 0; c < 6; c++) step();
    chk("lock_order3", (delivered.size() > 2) ? delivered[2].data : 0, 32'h23);
    chk("lock_order4", (delivered.size() > 3) ? delivered[3].data : 0, 32'h01);

    // Random traffic with a reset dropped into the middle of it.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++)
        if (stim_q[i].size() == 0 && $urandom_range(1, 0) == 1)
          stim_q[i].push_back($urandom);
      oup_ready = $urandom_range(1, 0) == 1;
      if (n == 300) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", oup_valid, 1'b0);
        chk("midrst_data", oup_data, 0);
        chk("midrst_idx", oup_idx, 0);
        model_clear();
        drive_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      step();
    end
    oup_ready = 1'b1;
    for (int c = 0; c < 60; c++)
      if (out_q.size() > 0 || stim_q[0].size() + stim_q[1].size() +
          stim_q[2].size() + stim_q[3].size() > 0) step();
    chk("drain_done", out_q.size(), 0);

    // Three inputs, no lock: a stalled request yields to a newer, closer one.
    full_reset();
    valid3 = 3'b010;
    data3 = {8'h22, 8'h11, 8'h00};
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("nolock_full", ready3, 0);
    valid3 = 3'b011;
    oup_ready3 = 1'b1;
    @(posedge clk);
    #1;
    chk("nolock_switch", ready3, 3'b001);

    // Three inputs: wrap from 2 back to the start of the ring.
    valid3 = '0;
    full_reset();
    valid3 = 3'b110;
    oup_ready3 = 1'b1;
    @(negedge clk);
    chk("wrap_empty", oup_valid3, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("wrap_valid", oup_valid3, 1'b1);
      chk("wrap_idx", oup_idx3, (k % 2 == 1) ? 1 : 2);
      chk("wrap_data", oup_data3, (k % 2 == 1) ? 8'h11 : 8'h22);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_spill_arbiter.md
# rr_spill_arbiter

Round-robin arbiter that shares one valid/ready output stream among `NumInp` requesting streams. The output is registered through a `spill_register` instance, so no combinational path runs between any input port and the output port. It sits in front of a shared downstream resource, such as a memory port or interconnect link, that several producers must take turns using at full throughput.

## Interface
- `NumInp`, default 4: number of requesting input streams, ≥1.
- `DataWidth`, default 32: payload width per stream.
- `LockIn`, default 1: 1 = hold an issued grant until its handshake completes; 0 = re-arbitrate every cycle.
- `IdxWidth`, derived (not overridable): `NumInp > 1 ? $clog2(NumInp) : 1`.

Ports:
- `clk_i`  in  1  clock; all state is on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `inp_valid_i`  in  NumInp  per-input valid.
- `inp_ready_o`  out  NumInp  per-input ready; one-hot or zero.
- `inp_data_i`  in  NumInp×DataWidth  per-input payload, packed; index i occupies bits [i*DataWidth +: DataWidth].
- `oup_valid_o`  out  1  output valid.
- `oup_ready_i`  in  1  output ready.
- `oup_data_o`  out  DataWidth  granted payload.
- `oup_idx_o`  out  IdxWidth  index of the input that sourced `oup_data_o`.

## Operation
- **Internal stream.** The arbiter drives an internal stream (`arb_valid`, `arb_data`, `arb_idx`) into the spill register and receives `arb_ready` back.
- **Arbitration.**
  - Pointer `rr_q` (IdxWidth bits).
  - The grant goes to the first i with `inp_valid_i[i]=1`, searching cyclically from `rr_q` upward.
  - `arb_valid = |inp_valid_i`.
  - `inp_ready_o[g] = arb_ready` for the granted index g only; all other ready bits are 0.
- **Pointer update.**
  - On an internal handshake (`arb_valid && arb_ready`), `rr_q <= g+1`.
  - If `g == NumInp-1`, `rr_q <= 0`. Wrap is explicit; no power-of-two assumption.
  - With no handshake, `rr_q` holds.
- **Lock (`LockIn=1`).**
  - If `arb_valid && !arb_ready`, set `lock_q=1` and latch `lock_idx_q=g`.
  - While `lock_q=1`, the grant is forced to `lock_idx_q`.
  - `lock_q` clears on the next handshake.
  - Inputs must hold valid and data stable until ready. Withdrawing valid is a protocol violation; behaviour is undefined and an assertion fires.
- **No lock (`LockIn=0`).** The grant is recomputed every cycle. The pointer rule is unchanged.
- **`NumInp=1`.** No arbitration logic. `rr_q` is constant 0 and `oup_idx_o=0`.
- **Output.** The spill register carries `{arb_idx, arb_data}`, width `DataWidth+IdxWidth`.
  - `oup_valid_o`, `oup_data_o` and `oup_idx_o` come from the spill register outputs only.

## Timing
- **Reset values.**
  - `oup_valid_o=0`, `oup_data_o=0`, `oup_idx_o=0`.
  - `rr_q=0`, `lock_q=0`, `lock_idx_q=0`.
  - `inp_ready_o=0` while all valids are low.
- **Latency and throughput.**
  - Input handshake in cycle t gives `oup_valid_o=1` in cycle t+1.
  - Sustained throughput is 1 transfer/cycle while `oup_ready_i=1`.
- **Combinational paths.**
  - `inp_ready_o` depends combinationally on `inp_valid_i` (allowed) and on registered spill state.
  - `inp_ready_o` never depends on `oup_ready_i`.
  - No path from any input port to any output-side port.
- **Backpressure.**
  - With `oup_ready_i=0`, the arbiter accepts exactly 2 transfers, then `inp_ready_o` goes all zero.
  - After `oup_ready_i` rises, `inp_ready_o` is re-asserted one cycle later.
  - Buffered items emerge in acceptance order.
- **Simultaneous events.**
  - A new request arriving in the same cycle as a handshake is considered next cycle against the updated `rr_q`.
  - Output handshake and input handshake in the same cycle are both honoured.
- **Reset mid-operation.** Buffered transfers are discarded and all state returns to reset values immediately (asynchronous).

## Structure
- No shared-package entries; `IdxWidth` is a local derived parameter.
- One sub-module: `spill_register` with `T_w = DataWidth+IdxWidth`, the existing codebase cell, instantiated unmodified.
- The arbitration tree is a single always_comb cyclic priority search, kept in this module.

## Test plan
- **Reset:** assert `rst_ni=0` mid-burst → all outputs 0 within the same cycle; `rr_q=0` after release.
- **Fairness:** NumInp=4, all valid continuously, `oup_ready_i=1` → `oup_idx_o` sequence 0,1,2,3,0,1… with one item per cycle from cycle 1.
- **Non-power-of-two wrap:** NumInp=3, inputs 1 and 2 valid → `oup_idx_o` alternates 1,2,1,2; `rr_q` wraps 2→0 correctly.
- **Backpressure:** `oup_ready_i=0`, input 0 sends 0xA, 0xB, 0xC → 0xA and 0xB accepted, then `inp_ready_o=0`. Raise ready → 0xA, 0xB, then 0xC delivered in order, with no loss or duplication.
- **Lock:** LockIn=1, spill full, input 2 waiting, input 0 then becomes valid → grant stays on 2 until its handshake. LockIn=0 → grant switches to per-cycle round-robin.
- **Random:** random valid and ready at 50% density with a scoreboard per input → per-input order preserved, every item delivered once with correct `oup_idx_o`, no input starves beyond NumInp grants.
